afb_accelerator_master: RTL and testbench

- Core-side AFB initiator that drives the accelerator's AFB request/response pipes.
- Converts a simple valid/ready host command (register read/write) into one 74-bit AFB request, waits for the 33-bit AFB response and returns it to the host.
- Only one transaction is outstanding at a time.
- A response timeout prevents a hung accelerator from stalling the core; late responses after a timeout are drained.

---
 rtl/afb_accelerator_master.sv | 158 +++++++++++++++
 tb/tb_afb_accelerator_master.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afb_accelerator_master.sv
// Core-side AFB initiator: turns one host valid/ready register command into
// a single 74-bit AFB request, waits for the 33-bit response and hands it
// back to the host. One transaction in flight; a response timeout protects
// the core, and a response that arrives after a timeout is drained so that
// requests and responses stay paired in order.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a host command (unless a late response is owed)
// SEND_REQ | request word presented on the request pipe, awaiting ack
// WAIT_RSP | response pipe open, timeout counter running
// DELIVER  | response held for the host until rsp_ready
module afb_accelerator_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_read,
    input  logic                 cmd_lock,
    input  logic [3:0]           cmd_byte_mask,
    input  logic [35:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] txn_count,
    output logic                 AFB_ACCELERATOR_REQUEST_pipe_write_req,
    input  logic                 AFB_ACCELERATOR_REQUEST_pipe_write_ack,
    output logic [73:0]          AFB_ACCELERATOR_REQUEST_pipe_write_data,
    output logic                 AFB_ACCELERATOR_RESPONSE_pipe_read_req,
    input  logic                 AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
    input  logic [32:0]          AFB_ACCELERATOR_RESPONSE_pipe_read_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_REQ = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    // Last counter value of the response window; unused when the timeout is disabled.
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [73:0]          req_data_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_error_q;
    logic                 rsp_timeout_q;
    logic [CNT_WIDTH-1:0] txn_count_q;
    logic [CNT_WIDTH-1:0] tmo_cnt_q;
    logic                 drain_pending_q;

    logic                 cmd_fire;
    logic                 tmo_hit;

    assign cmd_fire = cmd_valid & cmd_ready;
    // A response arriving on the expiry cycle takes priority over the timeout.
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) state_d = SEND_REQ;
            end
            SEND_REQ: begin
                if (AFB_ACCELERATOR_REQUEST_pipe_write_ack) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (AFB_ACCELERATOR_RESPONSE_pipe_read_ack || tmo_hit) state_d = DELIVER;
            end
            DELIVER: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is masked by reset so it reads 0 while reset is held.
    always_comb begin
        cmd_ready                              = (state_q == IDLE) && !drain_pending_q && !reset;
        AFB_ACCELERATOR_REQUEST_pipe_write_req = (state_q == SEND_REQ);
        AFB_ACCELERATOR_RESPONSE_pipe_read_req = (state_q == WAIT_RSP) || drain_pending_q;
        rsp_valid                              = (state_q == DELIVER);
        busy                                   = (state_q != IDLE) || drain_pending_q;
    end

    // Request capture, response capture, timeout counter, drain flag and transaction count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_data_q      <= '0;
            rsp_rdata_q     <= '0;
            rsp_error_q     <= 1'b0;
            rsp_timeout_q   <= 1'b0;
            txn_count_q     <= '0;
            tmo_cnt_q       <= '0;
            drain_pending_q <= 1'b0;
        end else begin
            if (state_q == IDLE && cmd_fire) begin
                req_data_q <= {cmd_lock, cmd_read, cmd_byte_mask, cmd_addr,
                               cmd_read ? 32'h0 : cmd_wdata};
            end

            if (state_q == SEND_REQ && AFB_ACCELERATOR_REQUEST_pipe_write_ack) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT_RSP) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            // Drain never overlaps WAIT_RSP: new commands are blocked while it is owed.
            if (drain_pending_q && AFB_ACCELERATOR_RESPONSE_pipe_read_ack) begin
                drain_pending_q <= 1'b0;
            end

            if (state_q == WAIT_RSP) begin
                if (AFB_ACCELERATOR_RESPONSE_pipe_read_ack) begin
                    rsp_error_q   <= AFB_ACCELERATOR_RESPONSE_pipe_read_data[32];
                    rsp_rdata_q   <= req_data_q[72] ? AFB_ACCELERATOR_RESPONSE_pipe_read_data[31:0]
                                                    : 32'h0;
                    rsp_timeout_q <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_error_q     <= 1'b1;
                    rsp_rdata_q     <= 32'h0;
                    rsp_timeout_q   <= 1'b1;
                    drain_pending_q <= 1'b1;
                end
            end

            if (state_q == DELIVER && rsp_ready) begin
                txn_count_q <= txn_count_q + 1'b1;
            end
        end
    end

    assign rsp_rdata                               = rsp_rdata_q;
    assign rsp_error                               = rsp_error_q;
    assign rsp_timeout                             = rsp_timeout_q;
    assign txn_count                               = txn_count_q;
    assign AFB_ACCELERATOR_REQUEST_pipe_write_data = req_data_q;

endmodule

// File: tb/tb_afb_accelerator_master.sv
// Directed bench for afb_accelerator_master. Small timeout (8) and a 4-bit
// transaction counter keep the timeout and wrap scenarios short.
module tb_afb_accelerator_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_read, cmd_lock;
    logic [3:0]  cmd_byte_mask;
    logic [35:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error, rsp_timeout, busy;
    logic [3:0]  txn_count;
    logic        wr_req, wr_ack;
    logic [73:0] wr_data;
    logic        rd_req, rd_ack;
    logic [32:0] rd_data;

    int checks   = 0;
    int failures = 0;

    afb_accelerator_master #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
        .clk                                     (clk),
        .reset                                   (reset),
        .cmd_valid                               (cmd_valid),
        .cmd_ready                               (cmd_ready),
        .cmd_read                                (cmd_read),
        .cmd_lock                                (cmd_lock),
        .cmd_byte_mask                           (cmd_byte_mask),
        .cmd_addr                                (cmd_addr),
        .cmd_wdata                               (cmd_wdata),
        .rsp_valid                               (rsp_valid),
        .rsp_ready                               (rsp_ready),
        .rsp_rdata                               (rsp_rdata),
        .rsp_error                               (rsp_error),
        .rsp_timeout                             (rsp_timeout),
        .busy                                    (busy),
        .txn_count                               (txn_count),
        .AFB_ACCELERATOR_REQUEST_pipe_write_req  (wr_req),
        .AFB_ACCELERATOR_REQUEST_pipe_write_ack  (wr_ack),
        .AFB_ACCELERATOR_REQUEST_pipe_write_data (wr_data),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_req  (rd_req),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_ack  (rd_ack),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_data (rd_data)
    );

    always #5 clk = ~clk;

    // Present a command for one cycle; returns at the negedge after acceptance (SEND_REQ).
    task automatic issue_cmd(input logic rd, input logic lk, input logic [3:0] m,
                             input logic [35:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_read = rd; cmd_lock = lk;
        cmd_byte_mask = m; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic ack_write();
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
    endtask

    task automatic give_rsp(input logic [32:0] r);
        rd_ack = 1'b1; rd_data = r;
        @(negedge clk);
        rd_ack = 1'b0; rd_data = '0;
    endtask

    task automatic host_take();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic quick_txn(input logic [31:0] d);
        issue_cmd(1'b0, 1'b0, 4'hF, 36'h40, d);
        ack_write();
        give_rsp(33'h0);
        host_take();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, wr_req, rd_req, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {cmd_ready, rsp_valid, wr_req, rd_req, busy});
        end
        checks++;
        if ({txn_count, rsp_rdata, rsp_error, rsp_timeout, wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_data cnt=%h rdata=%h err=%b to=%b wd=%h want all 0",
                     txn_count, rsp_rdata, rsp_error, rsp_timeout, wr_data);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write();
        logic [73:0] exp;
        exp = {1'b0, 1'b0, 4'hF, 36'h0_0000_0010, 32'hCAFEBABE};
        issue_cmd(1'b0, 1'b0, 4'hF, 36'h10, 32'hCAFEBABE);
        checks++;
        if (wr_req !== 1'b1 || wr_data !== exp) begin
            failures++;
            $display("FAIL wr_request req=%b data=%h want 1 %h", wr_req, wr_data, exp);
        end
        checks++;
        if (wr_data[38:34] !== 5'd4 || wr_data[72] !== 1'b0) begin
            failures++;
            $display("FAIL wr_regidx idx=%0d rd=%b want 4 0", wr_data[38:34], wr_data[72]);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy cmd_ready=%b busy=%b want 0 1", cmd_ready, busy);
        end
        ack_write();
        checks++;
        if (wr_req !== 1'b0 || rd_req !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_waitrsp wr_req=%b rd_req=%b rsp_valid=%b want 0 1 0", wr_req, rd_req, rsp_valid);
        end
        give_rsp(33'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL wr_rsp valid=%b rdata=%h err=%b to=%b want 1 0 0 0",
                     rsp_valid, rsp_rdata, rsp_error, rsp_timeout);
        end
        host_take();
        checks++;
        if (rsp_valid !== 1'b0 || txn_count !== 4'd1 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_done valid=%b cnt=%0d cmd_ready=%b want 0 1 1", rsp_valid, txn_count, cmd_ready);
        end
    endtask

    task automatic test_read_backpressure();
        logic [73:0] exp;
        exp = {1'b0, 1'b1, 4'hF, 36'h0_0000_0014, 32'h0};
        issue_cmd(1'b1, 1'b0, 4'hF, 36'h14, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_req !== 1'b1 || wr_data !== exp) begin
                failures++;
                $display("FAIL rd_stall%0d req=%b data=%h want 1 %h", i, wr_req, wr_data, exp);
            end
            @(negedge clk);
        end
        ack_write();
        give_rsp(33'h0_12345678);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp valid=%b rdata=%h err=%b to=%b want 1 12345678 0 0",
                     rsp_valid, rsp_rdata, rsp_error, rsp_timeout);
        end
        host_take();
        checks++;
        if (txn_count !== 4'd2) begin
            failures++;
            $display("FAIL rd_count got=%0d want 2", txn_count);
        end
    endtask

    task automatic test_error();
        issue_cmd(1'b0, 1'b1, 4'h3, 36'h20, 32'h11111111);
        checks++;
        if (wr_data[73] !== 1'b1 || wr_data[71:68] !== 4'h3 || wr_data[31:0] !== 32'h11111111) begin
            failures++;
            $display("FAIL err_fields lock=%b mask=%h wd=%h want 1 3 11111111",
                     wr_data[73], wr_data[71:68], wr_data[31:0]);
        end
        ack_write();
        give_rsp(33'h1_55AA55AA);
        checks++;
        if (rsp_error !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL err_rsp err=%b to=%b rdata=%h want 1 0 0", rsp_error, rsp_timeout, rsp_rdata);
        end
        host_take();
        checks++;
        if (txn_count !== 4'd3) begin
            failures++;
            $display("FAIL err_count got=%0d want 3", txn_count);
        end
    endtask

    task automatic test_timeout();
        issue_cmd(1'b1, 1'b0, 4'hF, 36'h24, 32'h0);
        ack_write();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || rd_req !== 1'b1) begin
                failures++;
                $display("FAIL to_wait%0d rsp_valid=%b rd_req=%b want 0 1", i, rsp_valid, rd_req);
            end
            @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL to_rsp valid=%b to=%b err=%b rdata=%h want 1 1 1 0",
                     rsp_valid, rsp_timeout, rsp_error, rsp_rdata);
        end
        host_take();
        checks++;
        if (txn_count !== 4'd4 || cmd_ready !== 1'b0 || busy !== 1'b1 || rd_req !== 1'b1) begin
            failures++;
            $display("FAIL to_drain cnt=%0d cmd_ready=%b busy=%b rd_req=%b want 4 0 1 1",
                     txn_count, cmd_ready, busy, rd_req);
        end
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 36'h28; cmd_byte_mask = 4'hF; cmd_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_req !== 1'b0 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL to_block%0d wr_req=%b cmd_ready=%b want 0 0", i, wr_req, cmd_ready);
            end
        end
        give_rsp(33'h0_99999999);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0 || rsp_valid !== 1'b0 || txn_count !== 4'd4) begin
            failures++;
            $display("FAIL to_drained cmd_ready=%b busy=%b rd_req=%b valid=%b cnt=%0d want 1 0 0 0 4",
                     cmd_ready, busy, rd_req, rsp_valid, txn_count);
        end
        issue_cmd(1'b1, 1'b0, 4'hF, 36'h28, 32'h0);
        ack_write();
        give_rsp(33'h0_0BADF00D);
        checks++;
        if (rsp_rdata !== 32'h0BADF00D || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_next rdata=%h err=%b to=%b want 0badf00d 0 0", rsp_rdata, rsp_error, rsp_timeout);
        end
        host_take();
        checks++;
        if (txn_count !== 4'd5) begin
            failures++;
            $display("FAIL to_count got=%0d want 5", txn_count);
        end
    endtask

    task automatic test_hold();
        issue_cmd(1'b1, 1'b0, 4'hF, 36'h2C, 32'h0);
        ack_write();
        give_rsp(33'h0_13579BDF);
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 36'h30; cmd_wdata = 32'h5;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h13579BDF || rsp_error !== 1'b0 ||
                cmd_ready !== 1'b0 || wr_req !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d valid=%b rdata=%h err=%b cmd_ready=%b wr_req=%b want 1 13579bdf 0 0 0",
                         i, rsp_valid, rsp_rdata, rsp_error, cmd_ready, wr_req);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        host_take();
        checks++;
        if (txn_count !== 4'd6 || wr_req !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_done cnt=%0d wr_req=%b valid=%b want 6 0 0", txn_count, wr_req, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(1'b0, 1'b0, 4'hF, 36'h30, 32'h77);
        ack_write();
        checks++;
        if (rd_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre rd_req=%b want 1", rd_req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rd_req, wr_req, busy, rsp_valid, cmd_ready} !== 5'b0 || txn_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_async rd=%b wr=%b busy=%b valid=%b cmd_ready=%b cnt=%0d want 0 0 0 0 0 0",
                     rd_req, wr_req, busy, rsp_valid, cmd_ready, txn_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_nodrain rd_req=%b cmd_ready=%b want 0 1", rd_req, cmd_ready);
        end
        issue_cmd(1'b1, 1'b0, 4'hF, 36'h34, 32'h0);
        ack_write();
        give_rsp(33'h0_2468ACE0);
        checks++;
        if (rsp_rdata !== 32'h2468ACE0 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL rst_after rdata=%h err=%b want 2468ace0 0", rsp_rdata, rsp_error);
        end
        host_take();
        checks++;
        if (txn_count !== 4'd1) begin
            failures++;
            $display("FAIL rst_count got=%0d want 1", txn_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 14; i++) quick_txn(32'(i));
        checks++;
        if (txn_count !== 4'hF) begin
            failures++;
            $display("FAIL wrap_max got=%h want f", txn_count);
        end
        quick_txn(32'hFF);
        checks++;
        if (txn_count !== 4'h0) begin
            failures++;
            $display("FAIL wrap_zero got=%h want 0", txn_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_lock = 1'b0;
        cmd_byte_mask = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;
        test_reset();
        test_write();
        test_read_backpressure();
        test_error();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
